// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings used by the writeback stage and its helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        M2R_ALU  = 2'b00,
        M2R_LOAD = 2'b01,
        M2R_LINK = 2'b10,
        M2R_RSVD = 2'b11
    } mem_to_reg_e;

    // Encodings 101..111 are not named and behave as a full-word load.
    typedef enum logic [2:0] {
        LS_LW  = 3'b000,
        LS_LH  = 3'b001,
        LS_LHU = 3'b010,
        LS_LB  = 3'b011,
        LS_LBU = 3'b100
    } load_size_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic        valid;
        logic        regWrite;
        mem_to_reg_e memToReg;
        load_size_e  loadSize;
        logic [4:0]  writeReg;
        logic [31:0] aluResult;
        logic [31:0] readData;
        logic [31:0] pcPlus4;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian sub-word load extraction, sign/zero extension and misalignment detection.
module load_align
    import mips_pkg::*;
(
    input  load_size_e  loadSize_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] readData_i,
    output logic [31:0] loadData_o,
    output logic        misaligned_o
);

    logic [15:0] halfSel;
    logic [7:0]  byteSel;

    // Offset 0 addresses the most significant lane of the word.
    always_comb begin
        halfSel = offset_i[1] ? readData_i[15:0] : readData_i[31:16];
        case (offset_i)
            2'd0:    byteSel = readData_i[31:24];
            2'd1:    byteSel = readData_i[23:16];
            2'd2:    byteSel = readData_i[15:8];
            default: byteSel = readData_i[7:0];
        endcase
    end

    always_comb begin
        loadData_o   = readData_i;
        misaligned_o = (offset_i != 2'd0);
        case (loadSize_i)
            LS_LH: begin
                loadData_o   = {{16{halfSel[15]}}, halfSel};
                misaligned_o = offset_i[0];
            end
            LS_LHU: begin
                loadData_o   = {16'h0000, halfSel};
                misaligned_o = offset_i[0];
            end
            LS_LB: begin
                loadData_o   = {{24{byteSel[7]}}, byteSel};
                misaligned_o = 1'b0;
            end
            LS_LBU: begin
                loadData_o   = {24'h000000, byteSel};
                misaligned_o = 1'b0;
            end
            default: begin
                loadData_o   = readData_i;
                misaligned_o = (offset_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback pipeline register: selects the GPR write value, gates the write to one cycle per entry, counts retirements.
module wb_stage
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                memValid,
    input  logic                memRegWrite,
    input  logic [1:0]          memMemToReg,
    input  logic [2:0]          memLoadSize,
    input  logic [4:0]          memWriteReg,
    input  logic [31:0]         memAluResult,
    input  logic [31:0]         memReadData,
    input  logic [31:0]         memPcPlus4,
    input  logic                stall,
    input  logic                flush,
    output logic                regWrite,
    output logic [4:0]          writeReg,
    output logic [31:0]         writeData,
    output logic                misalign,
    output logic [RETIRE_W-1:0] retireCount
);

    wb_entry_t           entry_q, entry_d;
    logic                written_q, written_d;
    logic [RETIRE_W-1:0] retire_q, retire_d;

    logic        capture;
    logic        newValid;
    logic [31:0] loadData;
    logic        loadMisaligned;
    logic        misaligned;
    logic        firstCycle;

    // Flush forces a capture so a stalled entry is killed rather than held.
    always_comb begin
        capture   = ~stall | flush;
        newValid  = memValid & ~flush;
        entry_d   = entry_q;
        written_d = 1'b1;
        retire_d  = retire_q;
        if (capture) begin
            entry_d.valid     = newValid;
            entry_d.regWrite  = memRegWrite;
            entry_d.memToReg  = mem_to_reg_e'(memMemToReg);
            entry_d.loadSize  = load_size_e'(memLoadSize);
            entry_d.writeReg  = memWriteReg;
            entry_d.aluResult = memAluResult;
            entry_d.readData  = memReadData;
            entry_d.pcPlus4   = memPcPlus4;
            written_d         = 1'b0;
            if (newValid) begin
                retire_d = retire_q + RETIRE_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entry_q   <= '0;
            written_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            entry_q   <= entry_d;
            written_q <= written_d;
            retire_q  <= retire_d;
        end
    end

    load_align u_load_align (
        .loadSize_i   (entry_q.loadSize),
        .offset_i     (entry_q.aluResult[1:0]),
        .readData_i   (entry_q.readData),
        .loadData_o   (loadData),
        .misaligned_o (loadMisaligned)
    );

    // Side effects (write, misalign pulse) happen only in the entry's first cycle.
    always_comb begin
        misaligned = (entry_q.memToReg == M2R_LOAD) & loadMisaligned;
        firstCycle = entry_q.valid & ~written_q;
        case (entry_q.memToReg)
            M2R_ALU:  writeData = entry_q.aluResult;
            M2R_LOAD: writeData = loadData;
            M2R_LINK: writeData = entry_q.pcPlus4 + 32'd4;
            default:  writeData = 32'h0000_0000;
        endcase
        regWrite    = firstCycle & entry_q.regWrite & ~misaligned & (entry_q.writeReg != REG_ZERO);
        misalign    = firstCycle & misaligned;
        writeReg    = entry_q.writeReg;
        retireCount = retire_q;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_wb_stage;

    localparam int RW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          memValid, memRegWrite;
    logic [1:0]    memMemToReg;
    logic [2:0]    memLoadSize;
    logic [4:0]    memWriteReg;
    logic [31:0]   memAluResult, memReadData, memPcPlus4;
    logic          stall, flush;
    logic          regWrite;
    logic [4:0]    writeReg;
    logic [31:0]   writeData;
    logic          misalign;
    logic [RW-1:0] retireCount;

    int errors = 0;
    int checks = 0;

    wb_stage #(.RETIRE_W(RW)) dut (
        .clock        (clock),
        .reset        (reset),
        .memValid     (memValid),
        .memRegWrite  (memRegWrite),
        .memMemToReg  (memMemToReg),
        .memLoadSize  (memLoadSize),
        .memWriteReg  (memWriteReg),
        .memAluResult (memAluResult),
        .memReadData  (memReadData),
        .memPcPlus4   (memPcPlus4),
        .stall        (stall),
        .flush        (flush),
        .regWrite     (regWrite),
        .writeReg     (writeReg),
        .writeData    (writeData),
        .misalign     (misalign),
        .retireCount  (retireCount)
    );

    always #5 clock = ~clock;

    // Behavioural model: the entry currently held, how many cycles it has been shown, and how many entries retired.
    bit          mReady = 0;
    bit          mKnown = 0;
    bit          mValid, mRw;
    logic [1:0]  mM2r;
    logic [2:0]  mLs;
    logic [4:0]  mWr;
    logic [31:0] mAlu, mRd, mPc;
    int          mAge;
    int unsigned mRetire;

    function automatic bit refMis(input logic [2:0] ls, input logic [1:0] off);
        if (ls == 3'd1 || ls == 3'd2) return off[0];
        if (ls == 3'd3 || ls == 3'd4) return 1'b0;
        return off != 2'd0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [2:0] ls, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] h, b;
        h = (w >> (off[1] ? 0 : 16)) & 32'hFFFF;
        b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
        case (ls)
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4:    return b;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] refData();
        case (mM2r)
            2'd0:    return mAlu;
            2'd1:    return refLoad(mLs, mAlu[1:0], mRd);
            2'd2:    return mPc + 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            mValid = 0; mRw = 0; mM2r = 0; mLs = 0; mWr = 0;
            mAlu = 0; mRd = 0; mPc = 0; mAge = 0; mRetire = 0;
            mKnown = 1; mReady = 1;
        end else if (!stall || flush) begin
            mValid = memValid && !flush;
            mRw = memRegWrite; mM2r = memMemToReg; mLs = memLoadSize; mWr = memWriteReg;
            mAlu = memAluResult; mRd = memReadData; mPc = memPcPlus4;
            mAge = 0;
            mKnown = !stall;
            if (mValid) mRetire = (mRetire + 1) % (1 << RW);
        end else if (mAge < 2) begin
            mAge = mAge + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clock) begin
        if (mReady) begin
            bit first, mis;
            first = mValid && mAge == 0;
            mis   = mM2r == 2'd1 && refMis(mLs, mAlu[1:0]);
            checkOutput("model.regWrite", {31'b0, regWrite}, {31'b0, first && mRw && !mis && mWr != 5'd0});
            checkOutput("model.misalign", {31'b0, misalign}, {31'b0, first && mis});
            checkOutput("model.retireCount", {{(32-RW){1'b0}}, retireCount}, mRetire);
            if (mKnown) begin
                checkOutput("model.writeReg", {27'b0, writeReg}, {27'b0, mWr});
                checkOutput("model.writeData", writeData, refData());
            end
        end
    end

    task automatic applyStimulus(input bit v, input bit rw, input logic [1:0] m2r, input logic [2:0] ls,
                                 input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd,
                                 input logic [31:0] pc, input bit st, input bit fl, input bit rs);
        memValid = v; memRegWrite = rw; memMemToReg = m2r; memLoadSize = ls; memWriteReg = wr;
        memAluResult = alu; memReadData = rd; memPcPlus4 = pc; stall = st; flush = fl; reset = rs;
        @(posedge clock);
        #1;
    endtask

    localparam logic [31:0] W = 32'h8001_FF7F;

    initial begin
        int hi;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset.regWrite", {31'b0, regWrite}, 0);
        checkOutput("reset.writeReg", {27'b0, writeReg}, 0);
        checkOutput("reset.writeData", writeData, 0);
        checkOutput("reset.misalign", {31'b0, misalign}, 0);
        checkOutput("reset.retire", {{(32-RW){1'b0}}, retireCount}, 0);

        applyStimulus(1, 1, 1, 0, 8, 32'h100, W, 0, 0, 0, 0);
        checkOutput("lw.regWrite", {31'b0, regWrite}, 1);
        checkOutput("lw.writeReg", {27'b0, writeReg}, 8);
        checkOutput("lw.writeData", writeData, 32'h8001_FF7F);
        checkOutput("lw.retire", {{(32-RW){1'b0}}, retireCount}, 1);

        applyStimulus(1, 1, 1, 3, 8, 32'h103, W, 0, 0, 0, 0);
        checkOutput("lb3.writeData", writeData, 32'h0000_007F);
        applyStimulus(1, 1, 1, 3, 8, 32'h100, W, 0, 0, 0, 0);
        checkOutput("lb0.writeData", writeData, 32'hFFFF_FF80);
        applyStimulus(1, 1, 1, 2, 8, 32'h102, W, 0, 0, 0, 0);
        checkOutput("lhu2.writeData", writeData, 32'h0000_FF7F);
        applyStimulus(1, 1, 1, 1, 8, 32'h100, W, 0, 0, 0, 0);
        checkOutput("lh0.writeData", writeData, 32'hFFFF_8001);
        checkOutput("loads.retire", {{(32-RW){1'b0}}, retireCount}, 5);

        applyStimulus(1, 1, 1, 1, 9, 32'h101, W, 0, 0, 0, 0);
        checkOutput("lhMis.regWrite", {31'b0, regWrite}, 0);
        checkOutput("lhMis.misalign", {31'b0, misalign}, 1);
        checkOutput("lhMis.retire", {{(32-RW){1'b0}}, retireCount}, 6);
        applyStimulus(1, 1, 1, 1, 9, 32'h101, W, 0, 1, 0, 0);
        checkOutput("lhMisHeld.misalign", {31'b0, misalign}, 0);
        checkOutput("lhMisHeld.retire", {{(32-RW){1'b0}}, retireCount}, 6);

        applyStimulus(1, 1, 2, 0, 31, 0, 0, 32'h0040_0004, 0, 0, 0);
        checkOutput("jal.writeData", writeData, 32'h0040_0008);
        checkOutput("jal.regWrite", {31'b0, regWrite}, 1);
        applyStimulus(1, 1, 0, 0, 0, 32'h1234, 0, 0, 0, 0, 0);
        checkOutput("x0.regWrite", {31'b0, regWrite}, 0);
        checkOutput("x0.retire", {{(32-RW){1'b0}}, retireCount}, 8);

        applyStimulus(1, 1, 0, 0, 5, 32'hABCD, 0, 0, 0, 0, 0);
        hi = int'(regWrite);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0, 6, 32'h9999, 0, 0, 1, 0, 0);
            hi += int'(regWrite);
        end
        checkOutput("stall.regWriteCycles", hi, 1);
        checkOutput("stall.writeReg", {27'b0, writeReg}, 5);
        checkOutput("stall.retire", {{(32-RW){1'b0}}, retireCount}, 9);

        applyStimulus(1, 1, 0, 0, 7, 32'h55, 0, 0, 1, 1, 0);
        checkOutput("stallFlush.regWrite", {31'b0, regWrite}, 0);
        checkOutput("stallFlush.retire", {{(32-RW){1'b0}}, retireCount}, 9);

        applyStimulus(1, 1, 0, 0, 3, 32'h77, 0, 0, 0, 0, 0);
        checkOutput("preReset.regWrite", {31'b0, regWrite}, 1);
        applyStimulus(1, 1, 0, 0, 3, 32'h77, 0, 0, 1, 1, 1);
        checkOutput("midReset.regWrite", {31'b0, regWrite}, 0);
        checkOutput("midReset.writeReg", {27'b0, writeReg}, 0);
        checkOutput("midReset.writeData", writeData, 0);
        checkOutput("midReset.misalign", {31'b0, misalign}, 0);
        checkOutput("midReset.retire", {{(32-RW){1'b0}}, retireCount}, 0);

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1, 1, 0, 0, 1, i, 0, 0, 0, 0, 0);
            if (i == 15) checkOutput("wrap.allOnes", {{(32-RW){1'b0}}, retireCount}, 15);
        end
        checkOutput("wrap.zero", {{(32-RW){1'b0}}, retireCount}, 0);

        for (int i = 0; i < 1500; i++) begin
            logic [4:0]  wr;
            logic [31:0] pc;
            wr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 3'($urandom_range(0, 7)),
                          wr, $urandom, $urandom, pc, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: RETIRE_W, default 32, width of retire counter.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 memValid  input  1  MEM stage presents an instruction this cycle.
REQ-005 memRegWrite  input  1  instruction writes a GPR.
REQ-006 memMemToReg  input  2  result select: 00 ALU, 01 load data, 10 link (PC+8), 11 reserved.
REQ-007 memLoadSize  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others treated as lw.
REQ-008 memWriteReg  input  5  destination register.
REQ-009 memAluResult  input  32  ALU result; bits [1:0] are the load byte offset.
REQ-010 memReadData  input  32  raw aligned word from data memory.
REQ-011 memPcPlus4  input  32  PC+4 of the instruction.
REQ-012 stall  input  1  hold WB pipeline register.
REQ-013 flush  input  1  kill the entry captured at this edge.
REQ-014 regWrite  output  1  register-file write enable.
REQ-015 writeReg  output  5  register-file write address.
REQ-016 writeData  output  32  register-file write data; also the forwarding value.
REQ-017 misalign  output  1  one-cycle flag: held load was misaligned, write suppressed.
REQ-018 retireCount  output  RETIRE_W  count of instructions retired.

Function
REQ-019 At each rising edge without stall, the WB register SHALL capture all mem* inputs; valid = memValid & ~flush.
REQ-020 When stall=1 and flush=0, the WB register SHALL hold its contents.
REQ-021 flush SHALL take priority over stall: the entry is invalidated at that edge.
REQ-022 Latency: inputs captured at edge N SHALL drive regWrite/writeReg/writeData during cycle N..N+1, so the register file writes at edge N+1.
REQ-023 writeData SHALL be memAluResult (00), the aligned and extended load value (01), memPcPlus4+4 mod 2^32 (10), or 0 (11).
REQ-024 Load alignment: lw uses the whole word; lh/lhu select the halfword at offset[1] (big-endian, offset 0 = bits 31:16); lb/lbu select byte offset (0 = bits 31:24); lh/lb sign-extend, lhu/lbu zero-extend.
REQ-025 Misaligned = lw with offset!=0, or lh/lhu with offset[0]=1; applies only when memToReg=01.
REQ-026 regWrite SHALL be valid & regWriteFlag & ~misaligned & (writeReg!=0) & ~written.
REQ-027 An internal written flag SHALL set after the first cycle an entry is presented and clear when a new entry is captured, so a stalled entry drives regWrite for exactly one cycle.
REQ-028 misalign SHALL pulse for exactly one cycle per misaligned valid load, in the entry's first cycle, under the same written gating.
REQ-029 retireCount SHALL increment by 1 in an entry's first cycle if valid (including misaligned and x0-targeted entries); it SHALL wrap from all-ones to 0.
REQ-030 writeReg and writeData SHALL reflect the held entry even when regWrite=0.

Reset
REQ-031 On reset=1 at an edge: valid=0, written=0, all held fields 0, retireCount=0; hence regWrite=0, writeReg=0, writeData=0, misalign=0 the following cycle.
REQ-032 reset SHALL override stall and flush; an in-flight entry is discarded without writing or retiring.

Structure
REQ-033 The memToReg and loadSize encodings, REG_ZERO=0 and REG_RA=31 SHALL live in shared package mips_pkg.
REQ-034 Load extraction/extension and misalignment detection SHALL be one combinational sub-module load_align.

Verification
REQ-035 lw, offset 0, memReadData=0x8001_FF7F, writeReg=8 -> next cycle regWrite=1, writeReg=8, writeData=0x8001_FF7F, retireCount=1.
REQ-036 lb offset 3 -> writeData=0x0000_007F; lb offset 0 -> 0xFFFF_FF80; lhu offset 2 -> 0x0000_FF7F; lh offset 0 -> 0xFFFF_8001 (same word).
REQ-037 lh, offset 1, writeReg=9 -> regWrite=0, misalign=1 for one cycle, retireCount increments by 1.
REQ-038 jal, memToReg=10, memPcPlus4=0x0040_0004, writeReg=31 -> writeData=0x0040_0008, regWrite=1; ALU op with writeReg=0 -> regWrite=0.
REQ-039 Entry captured then stall=1 for 3 cycles -> regWrite high exactly 1 cycle, retireCount +1 only; stall+flush together -> entry killed, regWrite=0.
REQ-040 reset asserted while a valid entry is held -> next cycle all outputs 0, retireCount=0, no register-file write.
